cr16_run_controller: RTL and testbench
======================================

Name: cr16_run_controller

Overview:
- Parametrised run/debug controller between the CR16 core and the board I/O; successor to the fixed "run until PC limit" enable logic in the CR16 top level.
- Gates the core enable with free-run, breakpoint, single-step and cycle-budget modes, counts executed cycles and reports why the core halted.
- Drives a selectable hex-digit bus to the seven_segment_hex_mapping instances.

Parameters:
P_DATA_WIDTH, 16, width of PC, result bus and memory data.
P_NUM_BREAKPOINTS, 2, number of PC breakpoint comparators (>=1).
P_CYCLE_COUNT_WIDTH, 24, width of executed-cycle counter and budget.
P_NUM_DIGITS, 6, hex digits driven on O_DISPLAY_BITS (4 bits each).

Ports:
I_CLK  in  1  clock; all state changes on its rising edge.
I_NRESET  in  1  asynchronous, active-low reset.
I_MODE  in  2  0 free-run, 1 run-to-breakpoint, 2 single-step, 3 cycle-budget; sampled every cycle.
I_START  in  1  single-cycle pulse: start from IDLE or resume from HALT.
I_STOP  in  1  single-cycle pulse: manual halt.
I_STEP  in  1  single-cycle pulse: execute exactly one core cycle.
I_BREAKPOINTS  in  P_NUM_BREAKPOINTS*P_DATA_WIDTH  packed breakpoint PCs, index 0 in LSBs.
I_BP_ENABLE  in  P_NUM_BREAKPOINTS  per-breakpoint enable.
I_CYCLE_BUDGET  in  P_CYCLE_COUNT_WIDTH  cycle limit for mode 3.
I_PC  in  P_DATA_WIDTH  core program counter.
I_RESULT_BUS  in  P_DATA_WIDTH  core result bus.
I_MEM_DATA  in  P_DATA_WIDTH  memory read data (BRAM port B).
I_DISPLAY_SEL  in  2  0 PC, 1 held result, 2 memory data, 3 cycle count.
O_CPU_ENABLE  out  1  core enable.
O_HALTED  out  1  high in HALT state.
O_HALT_CAUSE  out  3  0 NONE, 1 BREAKPOINT, 2 BUDGET, 3 MANUAL, 4 STEP.
O_BP_HIT_INDEX  out  max(1,$clog2(P_NUM_BREAKPOINTS))  index of breakpoint that caused the last halt.
O_CYCLE_COUNT  out  P_CYCLE_COUNT_WIDTH  enabled cycles since last start from IDLE.
O_DISPLAY_BITS  out  4*P_NUM_DIGITS  hex digit bus, digit 0 in LSBs.

Behaviour:
- Reset (async, I_NRESET=0): state IDLE; all outputs 0; held result 0; resume-mask 0. Reset mid-run drops O_CPU_ENABLE immediately.
- States: IDLE, RUN, STEP, HALT.
- halt_cond (combinational, RUN only): bp_match = mode 1 AND any i with I_BP_ENABLE[i] AND I_PC==bp[i] AND resume-mask clear; budget_hit = mode 3 AND O_CYCLE_COUNT >= I_CYCLE_BUDGET.
- O_CPU_ENABLE (combinational) = (RUN AND NOT halt_cond) OR STEP.
- IDLE: I_STOP has priority, stays IDLE. I_START clears the counter. It then goes to RUN in modes 0/1/3, or to HALT with cause NONE in mode 2. I_STEP clears the counter and goes to STEP.
- RUN, evaluated in this priority order:
  - bp_match: HALT, cause BREAKPOINT, O_BP_HIT_INDEX = lowest matching index.
  - budget_hit: HALT, cause BUDGET.
  - I_STOP: HALT, cause MANUAL. The core still executes that cycle.
  - I_START and I_STEP: ignored.
- STEP: enable high exactly one cycle, then HALT with cause STEP. All inputs are ignored during STEP.
- HALT: I_STOP is a no-op. I_STEP goes to STEP. I_START goes to RUN (mode != 2), otherwise stays in HALT. I_STEP and I_START together: I_STEP wins. The counter is not cleared on resume.
- Resume mask:
  - Set on any HALT to RUN transition.
  - Suppresses breakpoint match for the first RUN cycle only, so a resume from a breakpoint advances past it.
  - Cleared after that cycle.
- Mode 3 with budget 0, or budget already reached on resume: halts with zero enabled cycles.
- Cycle counter increments on each edge where O_CPU_ENABLE=1 and saturates at all-ones (no wrap).
- O_HALTED=1 iff state HALT. O_HALT_CAUSE and O_BP_HIT_INDEX are registered and hold until the next halt. Leaving IDLE resets cause to NONE.
- Held result register loads I_RESULT_BUS on every edge where O_CPU_ENABLE=1, and holds otherwise.
- O_DISPLAY_BITS is registered and updates every cycle in every state from the I_DISPLAY_SEL source. The source is zero-extended or truncated to 4*P_NUM_DIGITS, so there is one cycle of latency from a select or source change.

Test Plan:
- Reset, mode 0, I_START pulse: O_CPU_ENABLE=1 from the next cycle. After 10 cycles O_CYCLE_COUNT=10. I_STOP: HALT, cause 3, count 11, enable 0.
- Mode 1, bp[0]=0x0008 enabled, PC increments from 0: enable drops combinationally when PC=0x0008; HALT, cause 1, index 0. I_START: the PC=0x0008 cycle executes (mask), run continues.
- Mode 1, bp[0]=bp[1]=0x0004 both enabled: halt at PC 4, O_BP_HIT_INDEX=0. Disabled breakpoint at 0x0002: no halt there.
- Mode 3, budget=5, I_START: exactly 5 enabled cycles, then HALT cause 2. Budget 0: zero enabled cycles, immediate HALT cause 2.
- Mode 2, I_START then three I_STEP pulses spaced 3 cycles: enable high for exactly 1 cycle each, count=3, cause 4. I_STEP during RUN: ignored.
- I_NRESET low mid-RUN (count=7): enable, count, cause and display go to 0 without a clock edge. Display sel 3 with count 0x00ABCD: O_DISPLAY_BITS=0x00ABCD one cycle later.

Source files
------------

// File: rtl/cr16_run_controller.sv
// cr16_run_controller
//   Run/debug controller sitting between the CR16 core and the board I/O. Gates the core
//   enable according to free-run, run-to-breakpoint, single-step and cycle-budget modes,
//   counts enabled cycles, records why the core halted and drives a selectable hex digit bus.
//
// Ports
//   I_CLK, I_NRESET       clock, asynchronous active-low reset
//   I_MODE                0 free-run, 1 run-to-breakpoint, 2 single-step, 3 cycle-budget
//   I_START/I_STOP/I_STEP single-cycle control pulses
//   I_BREAKPOINTS         packed breakpoint PCs (index 0 in LSBs), I_BP_ENABLE per-breakpoint
//   I_CYCLE_BUDGET        cycle limit used in mode 3
//   I_PC, I_RESULT_BUS    core program counter and result bus
//   I_MEM_DATA            memory read data
//   I_DISPLAY_SEL         0 PC, 1 held result, 2 memory data, 3 cycle count
//   O_CPU_ENABLE          core enable
//   O_HALTED              high while halted
//   O_HALT_CAUSE          0 none, 1 breakpoint, 2 budget, 3 manual, 4 step
//   O_BP_HIT_INDEX        breakpoint responsible for the last breakpoint halt
//   O_CYCLE_COUNT         enabled cycles since the last start from idle (saturating)
//   O_DISPLAY_BITS        registered hex digit bus, digit 0 in LSBs
module cr16_run_controller #(
  parameter int unsigned P_DATA_WIDTH        = 16,
  parameter int unsigned P_NUM_BREAKPOINTS   = 2,
  parameter int unsigned P_CYCLE_COUNT_WIDTH = 24,
  parameter int unsigned P_NUM_DIGITS        = 6
) (
  input  logic                                          I_CLK,
  input  logic                                          I_NRESET,
  input  logic [1:0]                                    I_MODE,
  input  logic                                          I_START,
  input  logic                                          I_STOP,
  input  logic                                          I_STEP,
  input  logic [P_NUM_BREAKPOINTS*P_DATA_WIDTH-1:0]     I_BREAKPOINTS,
  input  logic [P_NUM_BREAKPOINTS-1:0]                  I_BP_ENABLE,
  input  logic [P_CYCLE_COUNT_WIDTH-1:0]                I_CYCLE_BUDGET,
  input  logic [P_DATA_WIDTH-1:0]                       I_PC,
  input  logic [P_DATA_WIDTH-1:0]                       I_RESULT_BUS,
  input  logic [P_DATA_WIDTH-1:0]                       I_MEM_DATA,
  input  logic [1:0]                                    I_DISPLAY_SEL,
  output logic                                          O_CPU_ENABLE,
  output logic                                          O_HALTED,
  output logic [2:0]                                    O_HALT_CAUSE,
  output logic [((P_NUM_BREAKPOINTS > 1) ? $clog2(P_NUM_BREAKPOINTS) : 1)-1:0] O_BP_HIT_INDEX,
  output logic [P_CYCLE_COUNT_WIDTH-1:0]                O_CYCLE_COUNT,
  output logic [4*P_NUM_DIGITS-1:0]                     O_DISPLAY_BITS
);

  localparam int unsigned IdxW  = (P_NUM_BREAKPOINTS > 1) ? $clog2(P_NUM_BREAKPOINTS) : 1;
  localparam int unsigned DispW = 4 * P_NUM_DIGITS;
  localparam int unsigned MaxDc = (P_DATA_WIDTH > P_CYCLE_COUNT_WIDTH) ?
                                  P_DATA_WIDTH : P_CYCLE_COUNT_WIDTH;
  // Wide enough for every source and the display, so sources zero-extend then truncate.
  localparam int unsigned SrcW  = (MaxDc > DispW) ? MaxDc : DispW;

  localparam logic [2:0] CauseNone   = 3'd0;
  localparam logic [2:0] CauseBp     = 3'd1;
  localparam logic [2:0] CauseBudget = 3'd2;
  localparam logic [2:0] CauseManual = 3'd3;
  localparam logic [2:0] CauseStep   = 3'd4;

  typedef enum logic [1:0] {StIdle, StRun, StStep, StHalt} state_e;

  state_e                         r_state_q, w_state_d;
  logic [2:0]                     r_cause_q, w_cause_d;
  logic [IdxW-1:0]                r_bp_idx_q, w_bp_idx_d;
  logic                           r_mask_q, w_mask_d;
  logic [P_CYCLE_COUNT_WIDTH-1:0] r_count_q, w_count_d;
  logic [P_DATA_WIDTH-1:0]        r_result_q;
  logic [DispW-1:0]               r_display_q;

  logic                           w_cnt_clr;
  logic                           w_bp_any;
  logic [IdxW-1:0]                w_bp_idx;
  logic                           w_run;
  logic                           w_bp_match;
  logic                           w_budget_hit;
  logic [SrcW-1:0]                w_disp_src;

  // Lowest enabled matching breakpoint wins: scan downwards so the last hit is the lowest.
  always_comb begin
    w_bp_any = 1'b0;
    w_bp_idx = '0;
    for (int i = P_NUM_BREAKPOINTS - 1; i >= 0; i--) begin
      if (I_BP_ENABLE[i] && (I_PC == I_BREAKPOINTS[i*P_DATA_WIDTH +: P_DATA_WIDTH])) begin
        w_bp_any = 1'b1;
        w_bp_idx = IdxW'(i);
      end
    end
  end

  assign w_run        = (r_state_q == StRun);
  // The resume mask lets a run resumed at a breakpoint PC execute past it.
  assign w_bp_match   = w_run && (I_MODE == 2'd1) && w_bp_any && !r_mask_q;
  assign w_budget_hit = w_run && (I_MODE == 2'd3) && (r_count_q >= I_CYCLE_BUDGET);
  assign O_CPU_ENABLE = (w_run && !(w_bp_match || w_budget_hit)) || (r_state_q == StStep);

  always_comb begin
    w_state_d  = r_state_q;
    w_cause_d  = r_cause_q;
    w_bp_idx_d = r_bp_idx_q;
    w_mask_d   = 1'b0;
    w_cnt_clr  = 1'b0;
    unique case (r_state_q)
      StIdle: begin
        if (I_STOP) begin
          w_state_d = StIdle;
        end else if (I_START) begin
          w_cnt_clr = 1'b1;
          w_cause_d = CauseNone;
          w_state_d = (I_MODE == 2'd2) ? StHalt : StRun;
        end else if (I_STEP) begin
          w_cnt_clr = 1'b1;
          w_cause_d = CauseNone;
          w_state_d = StStep;
        end
      end
      StRun: begin
        if (w_bp_match) begin
          w_state_d  = StHalt;
          w_cause_d  = CauseBp;
          w_bp_idx_d = w_bp_idx;
        end else if (w_budget_hit) begin
          w_state_d = StHalt;
          w_cause_d = CauseBudget;
        end else if (I_STOP) begin
          w_state_d = StHalt;
          w_cause_d = CauseManual;
        end
      end
      StStep: begin
        w_state_d = StHalt;
        w_cause_d = CauseStep;
      end
      StHalt: begin
        if (I_STEP) begin
          w_state_d = StStep;
        end else if (I_START && (I_MODE != 2'd2)) begin
          w_state_d = StRun;
          w_mask_d  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_count_d = r_count_q;
    if (w_cnt_clr) begin
      w_count_d = '0;
    end else if (O_CPU_ENABLE && !(&r_count_q)) begin
      w_count_d = r_count_q + 1'b1;
    end
  end

  always_comb begin
    w_disp_src = '0;
    unique case (I_DISPLAY_SEL)
      2'd0: w_disp_src = SrcW'(I_PC);
      2'd1: w_disp_src = SrcW'(r_result_q);
      2'd2: w_disp_src = SrcW'(I_MEM_DATA);
      2'd3: w_disp_src = SrcW'(r_count_q);
      default: w_disp_src = '0;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_state_q   <= StIdle;
      r_cause_q   <= CauseNone;
      r_bp_idx_q  <= '0;
      r_mask_q    <= 1'b0;
      r_count_q   <= '0;
      r_result_q  <= '0;
      r_display_q <= '0;
    end else begin
      r_state_q   <= w_state_d;
      r_cause_q   <= w_cause_d;
      r_bp_idx_q  <= w_bp_idx_d;
      r_mask_q    <= w_mask_d;
      r_count_q   <= w_count_d;
      if (O_CPU_ENABLE) begin
        r_result_q <= I_RESULT_BUS;
      end
      r_display_q <= w_disp_src[DispW-1:0];
    end
  end

  assign O_HALTED       = (r_state_q == StHalt);
  assign O_HALT_CAUSE   = r_cause_q;
  assign O_BP_HIT_INDEX = r_bp_idx_q;
  assign O_CYCLE_COUNT  = r_count_q;
  assign O_DISPLAY_BITS = r_display_q;

endmodule

// File: tb/tb_cr16_run_controller.sv
// Testbench for cr16_run_controller: directed scenarios with a small core model (PC advances
// on each enabled cycle). Expected values are queued as stimulus is applied and compared
// against the DUT when the queue is drained at the sample point.
module tb_cr16_run_controller;

  logic        I_CLK = 1'b0;
  logic        I_NRESET;
  logic [1:0]  I_MODE;
  logic        I_START, I_STOP, I_STEP;
  logic [31:0] I_BREAKPOINTS;
  logic [1:0]  I_BP_ENABLE;
  logic [23:0] I_CYCLE_BUDGET;
  logic [15:0] I_PC;
  logic [15:0] I_RESULT_BUS;
  logic [15:0] I_MEM_DATA;
  logic [1:0]  I_DISPLAY_SEL;
  logic        O_CPU_ENABLE, O_HALTED;
  logic [2:0]  O_HALT_CAUSE;
  logic [0:0]  O_BP_HIT_INDEX;
  logic [23:0] O_CYCLE_COUNT;
  logic [23:0] O_DISPLAY_BITS;

  typedef enum int {SigEn, SigHalted, SigCause, SigIdx, SigCount, SigDisp, SigPc} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  en_cnt = 0;
  int  en_base;

  cr16_run_controller dut (
    .I_CLK          (I_CLK),
    .I_NRESET       (I_NRESET),
    .I_MODE         (I_MODE),
    .I_START        (I_START),
    .I_STOP         (I_STOP),
    .I_STEP         (I_STEP),
    .I_BREAKPOINTS  (I_BREAKPOINTS),
    .I_BP_ENABLE    (I_BP_ENABLE),
    .I_CYCLE_BUDGET (I_CYCLE_BUDGET),
    .I_PC           (I_PC),
    .I_RESULT_BUS   (I_RESULT_BUS),
    .I_MEM_DATA     (I_MEM_DATA),
    .I_DISPLAY_SEL  (I_DISPLAY_SEL),
    .O_CPU_ENABLE   (O_CPU_ENABLE),
    .O_HALTED       (O_HALTED),
    .O_HALT_CAUSE   (O_HALT_CAUSE),
    .O_BP_HIT_INDEX (O_BP_HIT_INDEX),
    .O_CYCLE_COUNT  (O_CYCLE_COUNT),
    .O_DISPLAY_BITS (O_DISPLAY_BITS)
  );

  always #5 I_CLK = ~I_CLK;

  // Core model: PC advances on every enabled edge, result bus derived from PC.
  always @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) I_PC <= '0;
    else if (O_CPU_ENABLE) I_PC <= I_PC + 16'd1;
  end
  assign I_RESULT_BUS = I_PC ^ 16'h5A5A;

  // Enabled-cycle tally, sampled mid-cycle where the enable is stable.
  always @(negedge I_CLK) if (O_CPU_ENABLE) en_cnt <= en_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      SigEn:     return {31'd0, O_CPU_ENABLE};
      SigHalted: return {31'd0, O_HALTED};
      SigCause:  return {29'd0, O_HALT_CAUSE};
      SigIdx:    return {31'd0, O_BP_HIT_INDEX};
      SigCount:  return {8'd0, O_CYCLE_COUNT};
      SigDisp:   return {8'd0, O_DISPLAY_BITS};
      default:   return {16'd0, I_PC};
    endcase
  endfunction

  task automatic expect_val(input string tag, input sig_e s, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge I_CLK);
      #1;
    end
  endtask

  task automatic pulse(input bit start, input bit stop, input bit step);
    I_START = start;
    I_STOP  = stop;
    I_STEP  = step;
    tick();
    I_START = 1'b0;
    I_STOP  = 1'b0;
    I_STEP  = 1'b0;
  endtask

  task automatic do_reset();
    I_NRESET       = 1'b0;
    I_MODE         = 2'd0;
    I_START        = 1'b0;
    I_STOP         = 1'b0;
    I_STEP         = 1'b0;
    I_BREAKPOINTS  = '0;
    I_BP_ENABLE    = '0;
    I_CYCLE_BUDGET = '0;
    I_MEM_DATA     = '0;
    I_DISPLAY_SEL  = 2'd0;
    tick(2);
    I_NRESET = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    expect_val("rst_en", SigEn, 0);
    expect_val("rst_halted", SigHalted, 0);
    expect_val("rst_cause", SigCause, 0);
    expect_val("rst_count", SigCount, 0);
    expect_val("rst_disp", SigDisp, 0);
    drain();

    // Free run, then manual stop
    pulse(1, 0, 0);
    expect_val("run_en", SigEn, 1);
    expect_val("run_count0", SigCount, 0);
    drain();
    tick(10);
    expect_val("run_count10", SigCount, 10);
    drain();
    pulse(0, 1, 0);
    expect_val("stop_halted", SigHalted, 1);
    expect_val("stop_cause", SigCause, 3);
    expect_val("stop_count", SigCount, 11);
    expect_val("stop_en", SigEn, 0);
    drain();
    tick();
    expect_val("disp_pc", SigDisp, 11);
    drain();

    // Breakpoint at 8, then resume past it
    do_reset();
    I_MODE = 2'd1;
    I_BREAKPOINTS = {16'h0000, 16'h0008};
    I_BP_ENABLE = 2'b01;
    pulse(1, 0, 0);
    tick(8);
    expect_val("bp_pc", SigPc, 8);
    expect_val("bp_en_drop", SigEn, 0);
    drain();
    tick();
    expect_val("bp_halted", SigHalted, 1);
    expect_val("bp_cause", SigCause, 1);
    expect_val("bp_idx", SigIdx, 0);
    expect_val("bp_count", SigCount, 8);
    drain();
    pulse(1, 0, 0);
    expect_val("resume_en", SigEn, 1);
    drain();
    tick();
    expect_val("resume_pc", SigPc, 9);
    expect_val("resume_halted", SigHalted, 0);
    expect_val("resume_count", SigCount, 9);
    drain();

    // Two breakpoints at the same PC: lowest index reported
    do_reset();
    I_MODE = 2'd1;
    I_BREAKPOINTS = {16'h0004, 16'h0004};
    I_BP_ENABLE = 2'b11;
    pulse(1, 0, 0);
    tick(5);
    expect_val("dual_halted", SigHalted, 1);
    expect_val("dual_pc", SigPc, 4);
    expect_val("dual_idx", SigIdx, 0);
    drain();

    // Disabled breakpoint at 2 passed, enabled index 1 at 4 hits
    do_reset();
    I_MODE = 2'd1;
    I_BREAKPOINTS = {16'h0004, 16'h0002};
    I_BP_ENABLE = 2'b10;
    pulse(1, 0, 0);
    tick(2);
    expect_val("dis_pc2", SigPc, 2);
    expect_val("dis_en", SigEn, 1);
    drain();
    tick(3);
    expect_val("bp1_halted", SigHalted, 1);
    expect_val("bp1_cause", SigCause, 1);
    expect_val("bp1_idx", SigIdx, 1);
    expect_val("bp1_pc", SigPc, 4);
    drain();

    // Cycle budget 5, then resume with budget already reached
    do_reset();
    I_MODE = 2'd3;
    I_CYCLE_BUDGET = 24'd5;
    en_base = en_cnt;
    pulse(1, 0, 0);
    tick(8);
    expect_val("bud_halted", SigHalted, 1);
    expect_val("bud_cause", SigCause, 2);
    expect_val("bud_count", SigCount, 5);
    drain();
    check_val("bud_en_cycles", en_cnt - en_base, 5);
    pulse(1, 0, 0);
    tick(2);
    expect_val("bud_re_halted", SigHalted, 1);
    drain();
    check_val("bud_re_en_cycles", en_cnt - en_base, 5);

    // Budget 0: halts without any enabled cycle
    do_reset();
    I_MODE = 2'd3;
    I_CYCLE_BUDGET = 24'd0;
    en_base = en_cnt;
    pulse(1, 0, 0);
    expect_val("bud0_en", SigEn, 0);
    drain();
    tick();
    expect_val("bud0_halted", SigHalted, 1);
    expect_val("bud0_cause", SigCause, 2);
    expect_val("bud0_count", SigCount, 0);
    drain();
    check_val("bud0_en_cycles", en_cnt - en_base, 0);

    // Single-step mode
    do_reset();
    I_MODE = 2'd2;
    pulse(1, 0, 0);
    expect_val("ss_halted", SigHalted, 1);
    expect_val("ss_cause0", SigCause, 0);
    expect_val("ss_en0", SigEn, 0);
    drain();
    en_base = en_cnt;
    for (int k = 0; k < 3; k++) begin
      pulse(0, 0, 1);
      expect_val("step_en", SigEn, 1);
      drain();
      tick();
      expect_val("step_halted", SigHalted, 1);
      expect_val("step_en_off", SigEn, 0);
      expect_val("step_cause", SigCause, 4);
      drain();
      tick();
    end
    expect_val("step_count", SigCount, 3);
    drain();
    check_val("step_en_cycles", en_cnt - en_base, 3);

    // Step ignored while running; then step beats start in HALT
    I_MODE = 2'd0;
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    expect_val("run_step_halted", SigHalted, 0);
    expect_val("run_step_en", SigEn, 1);
    drain();
    tick();
    expect_val("run_step_still", SigHalted, 0);
    drain();
    pulse(0, 1, 0);
    expect_val("stop2_cause", SigCause, 3);
    drain();
    pulse(1, 0, 1);
    expect_val("both_en", SigEn, 1);
    drain();
    tick();
    expect_val("both_halted", SigHalted, 1);
    expect_val("both_cause", SigCause, 4);
    drain();

    // Asynchronous reset mid-run
    do_reset();
    I_DISPLAY_SEL = 2'd3;
    pulse(1, 0, 0);
    tick(7);
    expect_val("mid_count", SigCount, 7);
    expect_val("mid_disp", SigDisp, 6);
    drain();
    #2;
    I_NRESET = 1'b0;
    #1;
    expect_val("arst_en", SigEn, 0);
    expect_val("arst_count", SigCount, 0);
    expect_val("arst_cause", SigCause, 0);
    expect_val("arst_disp", SigDisp, 0);
    drain();
    I_NRESET = 1'b1;
    tick();

    // Display select with count 0x00ABCD, then memory and held-result sources
    I_MODE = 2'd3;
    I_CYCLE_BUDGET = 24'h00ABCD;
    I_DISPLAY_SEL = 2'd3;
    pulse(1, 0, 0);
    tick(32'h0000ABCD + 3);
    expect_val("big_count", SigCount, 32'h00ABCD);
    expect_val("big_cause", SigCause, 2);
    expect_val("big_disp", SigDisp, 32'h00ABCD);
    drain();
    I_MEM_DATA = 16'h1234;
    I_DISPLAY_SEL = 2'd2;
    #1;
    expect_val("disp_latency", SigDisp, 32'h00ABCD);
    drain();
    tick();
    expect_val("disp_mem", SigDisp, 32'h001234);
    drain();
    I_DISPLAY_SEL = 2'd1;
    tick();
    expect_val("disp_result", SigDisp, 32'h00F196);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
